pd2th_pdw: RTL and testbench

Parametrised two-threshold pulse detector that emits one Pulse Descriptor Word (PDW) per detected pulse over a valid/ready handshake. It is the successor to the single-output dual-threshold detector. It adds these behaviours:
- generic video and timestamp widths;
- a minimum-width reject;
- a maximum-width timeout;
- pulse repetition interval (PRI) measurement;
- a counter for PDWs dropped under back-pressure.

It sits between the video ADC front end and the PDW sorter/FIFO.

---
 rtl/pd2th_pdw.sv | 193 +++++++++++++++++++
 tb/tb_pd2th_pdw.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd2th_pdw.sv
// ---------------------------------------------------------------------------
// pd2th_pdw: two-threshold pulse detector emitting one PDW per pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pd2th_pdw #(
  parameter int VIDEO_SIZE = 10,
  parameter int TIME_SIZE  = 32,
  parameter int MIN_PW     = 2,
  parameter int MAX_PW     = 4096
) (
  input  logic                  clock_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [VIDEO_SIZE-1:0] video_i,
  input  logic [VIDEO_SIZE-1:0] threshold1_i,
  input  logic [VIDEO_SIZE-1:0] threshold2_i,
  output logic                  pdw_valid_o,
  input  logic                  pdw_ready_i,
  output logic [TIME_SIZE-1:0]  pdw_toa_o,
  output logic [TIME_SIZE-1:0]  pdw_pw_o,
  output logic [VIDEO_SIZE-1:0] pdw_pa_o,
  output logic [TIME_SIZE-1:0]  pdw_pri_o,
  output logic                  pdw_trunc_o,
  output logic [TIME_SIZE-1:0]  pulse_count_o,
  output logic [TIME_SIZE-1:0]  drop_count_o
);

  localparam logic [TIME_SIZE-1:0] c_min_pw = TIME_SIZE'(MIN_PW);
  localparam logic [TIME_SIZE-1:0] c_max_pw = TIME_SIZE'(MAX_PW);
  localparam logic [TIME_SIZE-1:0] c_one    = TIME_SIZE'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE   = 3'd1,
    ACTIVE = 3'd2,
    FALL   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TIME_SIZE-1:0]  time_q;
  logic [TIME_SIZE-1:0]  toa_q, toa_d;
  logic [VIDEO_SIZE-1:0] pa_q, pa_d;
  logic [TIME_SIZE-1:0]  last_toa_q;
  logic                  have_last_q;

  logic                  valid_q;
  logic [TIME_SIZE-1:0]  out_toa_q;
  logic [TIME_SIZE-1:0]  out_pw_q;
  logic [VIDEO_SIZE-1:0] out_pa_q;
  logic [TIME_SIZE-1:0]  out_pri_q;
  logic                  out_trunc_q;
  logic [TIME_SIZE-1:0]  pulse_count_q;
  logic [TIME_SIZE-1:0]  drop_count_q;

  logic                  w_above1;
  logic                  w_above2;
  logic                  w_end;
  logic                  w_timeout;
  logic                  w_load;
  logic                  w_gen;
  logic                  w_gen_trunc;
  logic [TIME_SIZE-1:0]  w_gen_pw;
  logic [TIME_SIZE-1:0]  w_elapsed;
  logic [TIME_SIZE-1:0]  w_pri;
  logic [VIDEO_SIZE-1:0] w_pa_max;

  assign w_above1  = (video_i >= threshold1_i);
  assign w_above2  = (video_i >= threshold2_i);
  // threshold2 wins over threshold1, so a sample only ends a pulse when it clears neither
  assign w_end     = !w_above2 && !w_above1;
  assign w_elapsed = time_q - toa_q;
  assign w_timeout = (w_elapsed == c_max_pw);
  assign w_pa_max  = (video_i > pa_q) ? video_i : pa_q;
  assign w_load    = !valid_q || pdw_ready_i;
  assign w_pri     = have_last_q ? (toa_q - last_toa_q) : '0;

  always_comb begin
    state_d     = state_q;
    toa_d       = toa_q;
    pa_d        = pa_q;
    w_gen       = 1'b0;
    w_gen_trunc = 1'b0;
    w_gen_pw    = w_elapsed;
    if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (w_above2) begin
            state_d = ACTIVE;
            toa_d   = time_q;
            pa_d    = video_i;
          end else if (w_above1) begin
            state_d = RISE;
            toa_d   = time_q;
            pa_d    = video_i;
          end
        end
        RISE: begin
          if (w_above2) begin
            state_d = ACTIVE;
            pa_d    = w_pa_max;
          end else if (!w_above1) begin
            state_d = IDLE;
          end else begin
            pa_d = w_pa_max;
          end
        end
        ACTIVE, FALL: begin
          if (w_end) begin
            state_d = IDLE;
            w_gen   = (w_elapsed >= c_min_pw);
          end else if (w_timeout) begin
            state_d     = HOLD;
            w_gen       = 1'b1;
            w_gen_trunc = 1'b1;
            w_gen_pw    = c_max_pw;
          end else if (w_above2) begin
            state_d = ACTIVE;
            pa_d    = w_pa_max;
          end else begin
            state_d = FALL;
          end
        end
        HOLD: begin
          if (!w_above1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      time_q        <= '0;
      toa_q         <= '0;
      pa_q          <= '0;
      last_toa_q    <= '0;
      have_last_q   <= 1'b0;
      valid_q       <= 1'b0;
      out_toa_q     <= '0;
      out_pw_q      <= '0;
      out_pa_q      <= '0;
      out_pri_q     <= '0;
      out_trunc_q   <= 1'b0;
      pulse_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (enable_i) begin
        time_q <= time_q + c_one;
      end
      state_q <= state_d;
      toa_q   <= toa_d;
      pa_q    <= pa_d;
      if (valid_q && pdw_ready_i) begin
        valid_q <= 1'b0;
      end
      // a load on the transfer edge overrides the clear above
      if (w_gen) begin
        pulse_count_q <= pulse_count_q + c_one;
        last_toa_q    <= toa_q;
        have_last_q   <= 1'b1;
        if (w_load) begin
          valid_q     <= 1'b1;
          out_toa_q   <= toa_q;
          out_pw_q    <= w_gen_pw;
          out_pa_q    <= pa_q;
          out_pri_q   <= w_pri;
          out_trunc_q <= w_gen_trunc;
        end else begin
          drop_count_q <= drop_count_q + c_one;
        end
      end
    end
  end

  assign pdw_valid_o   = valid_q;
  assign pdw_toa_o     = out_toa_q;
  assign pdw_pw_o      = out_pw_q;
  assign pdw_pa_o      = out_pa_q;
  assign pdw_pri_o     = out_pri_q;
  assign pdw_trunc_o   = out_trunc_q;
  assign pulse_count_o = pulse_count_q;
  assign drop_count_o  = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pd2th_pdw.sv
// ---------------------------------------------------------------------------
// tb_pd2th_pdw: directed bench for pd2th_pdw with a pulse-level reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pd2th_pdw;

  localparam int VS    = 10;
  localparam int TS    = 32;
  localparam int MINPW = 2;
  localparam int MAXPW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          ready = 1'b1;
  logic [VS-1:0] video = '0;
  logic [VS-1:0] th1 = 10'd100;
  logic [VS-1:0] th2 = 10'd200;

  logic          pdw_valid;
  logic [TS-1:0] pdw_toa, pdw_pw, pdw_pri, pulse_count, drop_count;
  logic [VS-1:0] pdw_pa;
  logic          pdw_trunc;

  pd2th_pdw #(
    .VIDEO_SIZE(VS),
    .TIME_SIZE (TS),
    .MIN_PW    (MINPW),
    .MAX_PW    (MAXPW)
  ) dut (
    .clock_i      (clk),
    .rst_ni       (rst_n),
    .enable_i     (en),
    .video_i      (video),
    .threshold1_i (th1),
    .threshold2_i (th2),
    .pdw_valid_o  (pdw_valid),
    .pdw_ready_i  (ready),
    .pdw_toa_o    (pdw_toa),
    .pdw_pw_o     (pdw_pw),
    .pdw_pa_o     (pdw_pa),
    .pdw_pri_o    (pdw_pri),
    .pdw_trunc_o  (pdw_trunc),
    .pulse_count_o(pulse_count),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a pulse is either absent, tentative (only th1 seen),
  // confirmed (th2 seen) or being waited out after a timeout.
  logic [TS-1:0] m_t, m_toa, m_last, m_pc, m_dc;
  logic [VS-1:0] m_pa;
  bit            m_in, m_conf, m_hold, m_have_last;
  bit            m_valid, m_otrunc;
  logic [TS-1:0] m_otoa, m_opw, m_opri;
  logic [VS-1:0] m_opa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_toa = 0; m_last = 0; m_pc = 0; m_dc = 0; m_pa = 0;
    m_in = 0; m_conf = 0; m_hold = 0; m_have_last = 0;
    m_valid = 0; m_otrunc = 0; m_otoa = 0; m_opw = 0; m_opri = 0; m_opa = 0;
  endtask

  task automatic model_emit(input logic [TS-1:0] pw, input bit tr);
    logic [TS-1:0] pri;
    pri = m_have_last ? (m_toa - m_last) : 0;
    m_pc++;
    m_last = m_toa;
    m_have_last = 1;
    if (!m_valid) begin
      m_valid = 1; m_otoa = m_toa; m_opw = pw; m_opa = m_pa; m_opri = pri; m_otrunc = tr;
    end else begin
      m_dc++;
    end
  endtask

  task automatic model_step();
    bit a1, a2;
    logic [TS-1:0] el;
    a2 = (video >= th2);
    a1 = (video >= th1);
    if (m_valid && ready) m_valid = 0;
    if (en) begin
      el = m_t - m_toa;
      if (m_hold) begin
        if (!a1) m_hold = 0;
      end else if (!m_in) begin
        if (a1 || a2) begin
          m_in = 1; m_conf = a2; m_toa = m_t; m_pa = video;
        end
      end else if (!m_conf) begin
        if (a2) begin
          m_conf = 1;
          if (video > m_pa) m_pa = video;
        end else if (!a1) begin
          m_in = 0;
        end else if (video > m_pa) begin
          m_pa = video;
        end
      end else if (!a1 && !a2) begin
        m_in = 0;
        if (el >= MINPW) model_emit(el, 0);
      end else if (el == MAXPW) begin
        m_in = 0; m_hold = 1;
        model_emit(MAXPW, 1);
      end else if (a2 && video > m_pa) begin
        m_pa = video;
      end
      m_t = m_t + 1;
    end
  endtask

  task automatic compare_all();
    chk("valid", {31'd0, pdw_valid}, {31'd0, m_valid});
    chk("toa", pdw_toa, m_otoa);
    chk("pw", pdw_pw, m_opw);
    chk("pa", {22'd0, pdw_pa}, {22'd0, m_opa});
    chk("pri", pdw_pri, m_opri);
    chk("trunc", {31'd0, pdw_trunc}, {31'd0, m_otrunc});
    chk("pulse_count", pulse_count, m_pc);
    chk("drop_count", drop_count, m_dc);
  endtask

  // Drive one sample, let the edge happen, then compare on the falling edge.
  task automatic step(input int v, input bit r, input bit e);
    video = VS'(v); ready = r; en = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int v, input int n);
    for (int i = 0; i < n; i++) step(v, ready, 1'b1);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    video = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset valid", {31'd0, pdw_valid}, 0);
    chk("reset pulse_count", pulse_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pulse: 50x5, 150, 300, 350, 400, 300, 150, 50
    ready = 1'b1;
    run(50, 5);
    run(150, 1); run(300, 1); run(350, 1); run(400, 1); run(300, 1); run(150, 1);
    run(50, 1);
    chk("basic valid", {31'd0, pdw_valid}, 1);
    chk("basic toa", pdw_toa, 5);
    chk("basic pw", pdw_pw, 6);
    chk("basic pa", {22'd0, pdw_pa}, 400);
    chk("basic pri", pdw_pri, 0);
    chk("basic trunc", {31'd0, pdw_trunc}, 0);
    chk("basic pulse_count", pulse_count, 1);
    run(50, 1);

    // Fake rise at T13..15
    run(150, 2); run(50, 1);
    chk("fake rise pulse_count", pulse_count, 1);
    chk("fake rise valid", {31'd0, pdw_valid}, 0);

    // Fake fall, toa 16
    run(150, 1); run(300, 1); run(150, 1); run(300, 1); run(50, 1);
    chk("fake fall pw", pdw_pw, 4);
    chk("fake fall pri", pdw_pri, 11);
    chk("fake fall pulse_count", pulse_count, 2);

    // Enable freeze mid-pulse: toa 22, frozen 3 cycles
    run(50, 1); run(300, 1);
    for (int i = 0; i < 3; i++) step(50, 1'b1, 1'b0);
    run(300, 1); run(50, 1);
    chk("freeze toa", pdw_toa, 22);
    chk("freeze pw", pdw_pw, 2);
    chk("freeze pri", pdw_pri, 6);

    // MIN_PW reject and PRI
    do_reset();
    run(50, 3); run(300, 1); run(50, 6);
    chk("spike pulse_count", pulse_count, 0);
    run(300, 2); run(50, 1);
    chk("pri1 toa", pdw_toa, 10);
    chk("pri1 pri", pdw_pri, 0);
    run(50, 17); run(300, 2); run(50, 1);
    chk("pri2 toa", pdw_toa, 30);
    chk("pri2 pri", pdw_pri, 20);
    chk("pri2 pulse_count", pulse_count, 2);

    // Timeout with MAX_PW = 8, video high from T=2
    do_reset();
    run(50, 2); run(300, 8); run(300, 1);
    chk("timeout valid", {31'd0, pdw_valid}, 1);
    chk("timeout pw", pdw_pw, 8);
    chk("timeout trunc", {31'd0, pdw_trunc}, 1);
    chk("timeout toa", pdw_toa, 2);
    run(300, 5); run(150, 1); run(300, 1);
    chk("hold pulse_count", pulse_count, 1);
    run(50, 1); run(300, 2); run(50, 1);
    chk("after hold toa", pdw_toa, 19);
    chk("after hold trunc", {31'd0, pdw_trunc}, 0);
    chk("after hold pri", pdw_pri, 17);

    // Back-pressure: three pulses with ready low
    do_reset();
    ready = 1'b0;
    run(50, 1); run(300, 2); run(50, 1);
    run(50, 1); run(300, 2); run(50, 1);
    run(50, 1); run(300, 2); run(50, 1);
    chk("bp held toa", pdw_toa, 1);
    chk("bp drop_count", drop_count, 2);
    chk("bp pulse_count", pulse_count, 3);
    run(50, 1); run(300, 2);
    step(50, 1'b1, 1'b1);
    chk("bp reload valid", {31'd0, pdw_valid}, 1);
    chk("bp reload toa", pdw_toa, 13);
    chk("bp reload pri", pdw_pri, 4);
    step(50, 1'b1, 1'b0);
    chk("bp drain while frozen", {31'd0, pdw_valid}, 0);

    // Async reset while ACTIVE
    run(50, 1); run(300, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", {31'd0, pdw_valid}, 0);
    chk("async toa", pdw_toa, 0);
    chk("async pw", pdw_pw, 0);
    chk("async pa", {22'd0, pdw_pa}, 0);
    chk("async pri", pdw_pri, 0);
    chk("async pulse_count", pulse_count, 0);
    chk("async drop_count", drop_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(50, 1); run(300, 2); run(50, 1);
    chk("post reset toa", pdw_toa, 1);
    chk("post reset pri", pdw_pri, 0);
    chk("post reset pulse_count", pulse_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
